// File: rtl/dmem_wait_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_wait_responder_if
// Data-memory handshake between the multicycle core (master) and the
// wait-state memory responder (slave).
//   MemRead / MemWrite : request strobes, held by the core until dReady
//   dAddress           : byte address
//   dWriteData         : write data
//   dByteEn            : write lane enables (only with DMEM_BYTE_MASK_EN)
//   dReadData          : read data, held until the next good read
//   dReady             : one-cycle completion pulse
//   dError             : rejected access, only ever high with dReady
// ---------------------------------------------------------------------------
interface dmem_wait_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
`ifdef DMEM_BYTE_MASK_EN
    logic [3:0]  dByteEn;
`endif
    logic [31:0] dReadData;
    logic        dReady;
    logic        dError;

`ifdef DMEM_BYTE_MASK_EN
    modport master (output MemRead, MemWrite, dAddress, dWriteData, dByteEn,
                    input  dReadData, dReady, dError);
    modport slave  (input  MemRead, MemWrite, dAddress, dWriteData, dByteEn,
                    output dReadData, dReady, dError);
`else
    modport master (output MemRead, MemWrite, dAddress, dWriteData,
                    input  dReadData, dReady, dError);
    modport slave  (input  MemRead, MemWrite, dAddress, dWriteData,
                    output dReadData, dReady, dError);
`endif
endinterface

// File: rtl/dmem_wait_responder.sv
// ---------------------------------------------------------------------------
// dmem_wait_responder
// Word-organised data memory for the multicycle core that answers every
// access after WAIT_CYCLES wait states with a one-cycle dReady pulse.
// Misaligned, out-of-range and read+write requests complete with dError and
// have no side effects.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (aborts any transaction in flight)
//   bus  - dmem_wait_responder_if.slave (request in, dReadData/dReady/dError out)
//
// Parameters:
//   ADDR_WIDTH  - byte-address bits decoded; 2^(ADDR_WIDTH-2) 32-bit words
//   WAIT_CYCLES - wait states between capture and response (0 allowed)
//
// Optional feature: define DMEM_BYTE_MASK_EN to add bus.dByteEn[3:0]; good
// writes then update only the enabled byte lanes (bit0 = bits 7:0).
// ---------------------------------------------------------------------------
module dmem_wait_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_wait_responder_if.slave  bus
);
    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
    localparam int CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state, stateNext;
    logic [CW-1:0]          waitCnt;
    logic [ADDR_WIDTH-3:0]  capIdx;
    logic [31:0]            capData;
    logic                   capRead, capWrite, capErr;
    logic [31:0]            readData;
    logic [31:0]            mem [DEPTH];
`ifdef DMEM_BYTE_MASK_EN
    logic [3:0]             capByteEn;
`endif

    // Live request decode, only meaningful while IDLE.
    logic reqValid, reqErr;
    assign reqValid = bus.MemRead | bus.MemWrite;
    assign reqErr   = (bus.dAddress[1:0] != 2'b00)
                    | ((bus.dAddress >> ADDR_WIDTH) != 32'd0)
                    | (bus.MemRead & bus.MemWrite);

    // Effective transaction: in IDLE the live inputs (they are being captured
    // this edge, and with zero wait states they complete on the same edge);
    // afterwards the captured copy, since the bus is ignored until IDLE.
    logic                  effRead, effWrite, effErr;
    logic [ADDR_WIDTH-3:0] effIdx;
    logic [31:0]           effData;
    logic [3:0]            effByteEn;

    always_comb begin
        if (state == IDLE) begin
            effRead  = bus.MemRead;
            effWrite = bus.MemWrite;
            effErr   = reqErr;
            effIdx   = bus.dAddress[ADDR_WIDTH-1:2];
            effData  = bus.dWriteData;
`ifdef DMEM_BYTE_MASK_EN
            effByteEn = bus.dByteEn;
`else
            effByteEn = 4'hF;
`endif
        end else begin
            effRead  = capRead;
            effWrite = capWrite;
            effErr   = capErr;
            effIdx   = capIdx;
            effData  = capData;
`ifdef DMEM_BYTE_MASK_EN
            effByteEn = capByteEn;
`else
            effByteEn = 4'hF;
`endif
        end
    end

    // Next-state logic. enterResp marks the edge on which the access takes
    // effect (memory write or read-data load).
    logic capture, enterResp, commitWrite, commitRead;

    always_comb begin
        stateNext = state;
        enterResp = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (reqValid) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        stateNext = RESP;
                        enterResp = 1'b1;
                    end else begin
                        stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                if (waitCnt == CW'(1)) begin
                    stateNext = RESP;
                    enterResp = 1'b1;
                end
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign commitWrite = enterResp & effWrite & ~effErr;
    assign commitRead  = enterResp & effRead  & ~effErr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            waitCnt   <= '0;
            capIdx    <= '0;
            capData   <= '0;
            capRead   <= 1'b0;
            capWrite  <= 1'b0;
            capErr    <= 1'b0;
            readData  <= '0;
`ifdef DMEM_BYTE_MASK_EN
            capByteEn <= '0;
`endif
        end else begin
            state <= stateNext;
            if (capture) begin
                capIdx   <= bus.dAddress[ADDR_WIDTH-1:2];
                capData  <= bus.dWriteData;
                capRead  <= bus.MemRead;
                capWrite <= bus.MemWrite;
                capErr   <= reqErr;
                waitCnt  <= CW'(WAIT_CYCLES);
`ifdef DMEM_BYTE_MASK_EN
                capByteEn <= bus.dByteEn;
`endif
            end else if (state == WAIT) begin
                waitCnt <= waitCnt - CW'(1);
            end
            if (commitRead)
                readData <= mem[effIdx];
        end
    end

    // Array contents survive reset; reset only blocks a write on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
        end else if (commitWrite) begin
            for (int b = 0; b < 4; b++)
                if (effByteEn[b])
                    mem[effIdx][8*b +: 8] <= effData[8*b +: 8];
        end
    end

    assign bus.dReadData = readData;
    assign bus.dReady    = (state == RESP);
    assign bus.dError    = (state == RESP) & capErr;

endmodule

// File: tb/tb_dmem_wait_responder.sv
module tb_dmem_wait_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_wait_responder_if bus2();
    dmem_wait_responder_if bus0();

    dmem_wait_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave));
    dmem_wait_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        int          sel;      // 0: WAIT_CYCLES=2 instance, 1: WAIT_CYCLES=0
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          expLat;   // negedges from request cycle to dReady
        bit          expErr;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] data);
        if (sel == 0) begin
            bus2.MemRead = rd; bus2.MemWrite = wr; bus2.dAddress = addr; bus2.dWriteData = data;
        end else begin
            bus0.MemRead = rd; bus0.MemWrite = wr; bus0.dAddress = addr; bus0.dWriteData = data;
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? bus2.dReady : bus0.dReady;
    endfunction
    function automatic logic errOut(input int sel);
        return (sel == 0) ? bus2.dError : bus0.dError;
    endfunction
    function automatic logic [31:0] rdata(input int sel);
        return (sel == 0) ? bus2.dReadData : bus0.dReadData;
    endfunction

    // Request driven just after an edge and held until dReady is seen.
    task automatic doAccess(input vec_t v);
        int lat;
        int strayErr;
        lat = 0;
        strayErr = 0;
        @(posedge clk); #1;
        drive(v.sel, v.rd, v.wr, v.addr, v.data);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rdy(v.sel)) begin lat = k; break; end
            if (errOut(v.sel)) strayErr++;
        end
        check({v.name, " latency"}, 32'(lat), 32'(v.expLat));
        check({v.name, " dError idle"}, 32'(strayErr), 32'd0);
        check({v.name, " dError"}, {31'd0, errOut(v.sel)}, {31'd0, v.expErr});
        check({v.name, " dReadData"}, rdata(v.sel), v.expRdata);
        @(posedge clk); #1;
        drive(v.sel, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check({v.name, " single pulse"}, {31'd0, rdy(v.sel)}, 32'd0);
    endtask

    initial begin
        int readyCnt;
        //         name        sel rd wr addr        data          lat err expRdata
        vecs[0]  = '{"wr010",   0, 0, 1, 32'h010, 32'hDEADBEEF, 4, 0, 32'h0};
        vecs[1]  = '{"rd010",   0, 1, 0, 32'h010, 32'h0,        4, 0, 32'hDEADBEEF};
        vecs[2]  = '{"pre004",  0, 0, 1, 32'h004, 32'h00000000, 4, 0, 32'hDEADBEEF};
        vecs[3]  = '{"pre020",  0, 0, 1, 32'h020, 32'h00000000, 4, 0, 32'hDEADBEEF};
        vecs[4]  = '{"misal",   0, 0, 1, 32'h012, 32'h12345678, 4, 1, 32'hDEADBEEF};
        vecs[5]  = '{"rd010b",  0, 1, 0, 32'h010, 32'h0,        4, 0, 32'hDEADBEEF};
        vecs[6]  = '{"oor200",  0, 1, 0, 32'h200, 32'h0,        4, 1, 32'hDEADBEEF};
        vecs[7]  = '{"rdwr004", 0, 1, 1, 32'h004, 32'h55555555, 4, 1, 32'hDEADBEEF};
        vecs[8]  = '{"rd004",   0, 1, 0, 32'h004, 32'h0,        4, 0, 32'h00000000};
        vecs[9]  = '{"w0wr010", 1, 0, 1, 32'h010, 32'hAAAA0001, 2, 0, 32'h0};
        vecs[10] = '{"w0rd010", 1, 1, 0, 32'h010, 32'h0,        2, 0, 32'hAAAA0001};
        vecs[11] = '{"w0misal", 1, 1, 0, 32'h011, 32'h0,        2, 1, 32'hAAAA0001};

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
`ifdef DMEM_BYTE_MASK_EN
        bus2.dByteEn = 4'hF;
        bus0.dByteEn = 4'hF;
`endif
        repeat (2) @(negedge clk);
        check("reset dReady", {31'd0, bus2.dReady}, 32'd0);
        check("reset dError", {31'd0, bus2.dError}, 32'd0);
        check("reset dReadData", bus2.dReadData, 32'd0);
        check("reset dReadData w0", bus0.dReadData, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) doAccess(vecs[i]);

        // Held read on the zero-wait instance: RESP and IDLE alternate.
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'h010, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("held dReady cyc%0d", k), {31'd0, bus0.dReady}, {31'd0, (k % 2 == 0)});
        end
        check("held dReadData", bus0.dReadData, 32'hAAAA0001);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset one cycle after a write request: aborted, nothing written.
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 32'h020, 32'hCAFEF00D);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        readyCnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus2.dReady) readyCnt++;
        end
        check("abort no dReady", 32'(readyCnt), 32'd0);
        check("abort dReadData reset", bus2.dReadData, 32'd0);
        doAccess('{"rd020", 0, 1, 0, 32'h020, 32'h0, 4, 0, 32'h00000000});

`ifdef DMEM_BYTE_MASK_EN
        doAccess('{"bm pre030", 0, 0, 1, 32'h030, 32'h11223344, 4, 0, 32'h0});
        bus2.dByteEn = 4'b0101;
        doAccess('{"bm wr030", 0, 0, 1, 32'h030, 32'hAABBCCDD, 4, 0, 32'h0});
        bus2.dByteEn = 4'b0000;
        doAccess('{"bm none", 0, 0, 1, 32'h030, 32'hFFFFFFFF, 4, 0, 32'h0});
        bus2.dByteEn = 4'b0000;
        doAccess('{"bm rd030", 0, 1, 0, 32'h030, 32'h0, 4, 0, 32'h11BB33DD});
        bus2.dByteEn = 4'hF;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
